// File: rtl/bw_clk_cl_param_hdr_pkg.sv
// Shared definitions for the parametrised cluster clock header:
// sequencer state encodings, width helpers and the scan-chain length.
package bw_clk_cl_param_hdr_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STAG  = 2'd2,
    ST_RUN   = 2'd3
  } hdr_state_e;

  localparam int STATE_W = 2;

  function automatic int hdr_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Chain: grst, gdbginit, adbginit, cken syncs, state, cnt, idx, cluster resets, dbginit reg.
  function automatic int hdr_scan_len(input int num_cl, input int sync_stg,
                                      input int cnt_w, input int idx_w);
    return sync_stg * (3 + num_cl) + STATE_W + cnt_w + idx_w + num_cl + 1;
  endfunction

endpackage

// File: rtl/bw_clk_gclk_gate.sv
// Glitch-free clock gate leaf: enable latched while clk is low, ANDed with clk.
module bw_clk_gclk_gate (
  input  logic clk,
  input  logic en,
  output logic gclk_out
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat = en;
  end

  assign gclk_out = clk & en_lat;

endmodule

// File: rtl/bw_clk_sync_n.sv
// STG-deep scannable synchroniser with asynchronous clear to 0.
// In scan mode the first stage takes si instead of d; the rest always shift.
module bw_clk_sync_n #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  input  logic se,
  input  logic si,
  output logic q
);

  logic [STG-1:0] stg_q;
  logic [STG-1:0] stg_d;

  always_comb begin
    stg_d = {stg_q[STG-2:0], (se ? si : d)};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  assign q = stg_q[STG-1];

endmodule

// File: rtl/bw_clk_cl_param_hdr.sv
// Cluster clock header: synchronised reset/debug-init, staggered cluster reset
// release, per-cluster gated clocks and a full scan chain through all state.
module bw_clk_cl_param_hdr
  import bw_clk_cl_param_hdr_pkg::*;
#(
  parameter int NUM_CL   = 2,
  parameter int SYNC_STG = 2,
  parameter int RST_HOLD = 16,
  parameter int STAGGER  = 4
) (
  input  logic              gclk,
  input  logic              arst_l,
  input  logic              grst_l,
  input  logic              adbginit_l,
  input  logic              gdbginit_l,
  input  logic [NUM_CL-1:0] cluster_cken,
  input  logic              se,
  input  logic              si,
  output logic [NUM_CL-1:0] rclk,
  output logic [NUM_CL-1:0] cluster_grst_l,
  output logic              dbginit_l,
  output logic              rst_done,
  output logic              so
);

  localparam int CNT_W  = $clog2(hdr_max3(RST_HOLD, STAGGER, 2));
  localparam int IDX_W  = $clog2(NUM_CL) + 1;
  localparam int CORE_W = STATE_W + CNT_W + IDX_W + NUM_CL;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_INIT = (STAGGER == 0) ? '0 : CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CL - 1);

  if (NUM_CL < 1 || NUM_CL > 16) begin : g_bad_num_cl
    $error("bw_clk_cl_param_hdr: NUM_CL must be 1..16");
  end
  if (SYNC_STG < 2 || SYNC_STG > 4) begin : g_bad_sync_stg
    $error("bw_clk_cl_param_hdr: SYNC_STG must be 2..4");
  end
  if (RST_HOLD < 1 || STAGGER < 0) begin : g_bad_timing
    $error("bw_clk_cl_param_hdr: RST_HOLD must be >= 1 and STAGGER >= 0");
  end

  logic              grst_s, gdbg_s, adbg_s;
  logic              grst_so, gdbg_so;
  logic [NUM_CL-1:0] cken_s;
  logic [NUM_CL:0]   ck_chain;
  logic              dbg_clr_n;

  // adbginit_l clears its own synchroniser so its release is re-timed to gclk
  assign dbg_clr_n = arst_l & adbginit_l;

  bw_clk_sync_n #(.STG(SYNC_STG)) u_sync_grst (
    .clk(gclk), .clr_n(arst_l), .d(grst_l), .se(se), .si(si), .q(grst_s)
  );
  assign grst_so = grst_s;

  bw_clk_sync_n #(.STG(SYNC_STG)) u_sync_gdbg (
    .clk(gclk), .clr_n(arst_l), .d(gdbginit_l), .se(se), .si(grst_so), .q(gdbg_s)
  );
  assign gdbg_so = gdbg_s;

  bw_clk_sync_n #(.STG(SYNC_STG)) u_sync_adbg (
    .clk(gclk), .clr_n(dbg_clr_n), .d(1'b1), .se(se), .si(gdbg_so), .q(adbg_s)
  );
  assign ck_chain[0] = adbg_s;

  for (genvar i = 0; i < NUM_CL; i++) begin : g_cken
    bw_clk_sync_n #(.STG(SYNC_STG)) u_sync_cken (
      .clk(gclk), .clr_n(arst_l), .d(cluster_cken[i]), .se(se),
      .si(ck_chain[i]), .q(cken_s[i])
    );
    assign ck_chain[i+1] = cken_s[i];
  end

  logic [CORE_W-1:0] core_q, core_d, core_fun;
  hdr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CL-1:0] cgrst_q, cgrst_d;
  logic              dbginit_q, dbginit_d;

  // Sequencer state packed in scan order: state first, cluster resets last
  assign state_q = hdr_state_e'(core_q[STATE_W-1:0]);
  assign cnt_q   = core_q[STATE_W +: CNT_W];
  assign idx_q   = core_q[STATE_W+CNT_W +: IDX_W];
  assign cgrst_q = core_q[CORE_W-1 -: NUM_CL];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cgrst_d = cgrst_q;
    if (!grst_s) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      idx_d   = '0;
      cgrst_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_STAG;
            idx_d   = '0;
            cnt_d   = STAG_INIT;
            if (STAGGER == 0) cgrst_d = '1;
            else              cgrst_d[0] = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STAG: begin
          if (STAGGER == 0) begin
            state_d = ST_RUN;
          end else if (cnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
            end else begin
              idx_d   = idx_q + 1'b1;
              cgrst_d = cgrst_q | (NUM_CL'(1) << (idx_q + 1'b1));
              cnt_d   = STAG_INIT;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_RESET;
      endcase
    end
    core_fun  = {cgrst_d, idx_d, cnt_d, state_d};
    core_d    = se ? {core_q[CORE_W-2:0], ck_chain[NUM_CL]} : core_fun;
    dbginit_d = se ? core_q[CORE_W-1] : (gdbg_s & adbg_s);
  end

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) core_q <= '0;
    else         core_q <= core_d;
  end

  always_ff @(posedge gclk or negedge dbg_clr_n) begin
    if (!dbg_clr_n) dbginit_q <= 1'b0;
    else            dbginit_q <= dbginit_d;
  end

  assign cluster_grst_l = cgrst_q;
  assign dbginit_l      = dbginit_q;
  assign rst_done       = (state_q == ST_RUN);
  assign so             = dbginit_q;

  // Clusters in reset and scan always get clocks
  logic [NUM_CL-1:0] gate_en;
  assign gate_en = cken_s | ~cgrst_q | {NUM_CL{se}};

  for (genvar i = 0; i < NUM_CL; i++) begin : g_gate
    bw_clk_gclk_gate u_gate (.clk(gclk), .en(gate_en[i]), .gclk_out(rclk[i]));
  end

endmodule

// File: tb/tb_bw_clk_cl_param_hdr.sv
// Directed bench for bw_clk_cl_param_hdr: a 4-cluster staggered instance and
// a 1-cluster all-at-once instance sharing one gclk.
module tb_bw_clk_cl_param_hdr;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic       arst_l, grst_l, adbginit_l, gdbginit_l, se, si;
  logic [3:0] cluster_cken;
  logic [3:0] rclk, cluster_grst_l;
  logic       dbginit_l, rst_done, so;

  logic       arst1_l, grst1_l, adbg1_l, gdbg1_l, se1, si1;
  logic [0:0] cken1, rclk1, cgrst1;
  logic       dbginit1_l, rst_done1, so1;

  int tests = 0;
  int fails = 0;

  bw_clk_cl_param_hdr #(.NUM_CL(4), .SYNC_STG(2), .RST_HOLD(16), .STAGGER(4)) u_dut (
    .gclk(gclk), .arst_l(arst_l), .grst_l(grst_l), .adbginit_l(adbginit_l),
    .gdbginit_l(gdbginit_l), .cluster_cken(cluster_cken), .se(se), .si(si),
    .rclk(rclk), .cluster_grst_l(cluster_grst_l), .dbginit_l(dbginit_l),
    .rst_done(rst_done), .so(so)
  );

  bw_clk_cl_param_hdr #(.NUM_CL(1), .SYNC_STG(2), .RST_HOLD(3), .STAGGER(0)) u_dut1 (
    .gclk(gclk), .arst_l(arst1_l), .grst_l(grst1_l), .adbginit_l(adbg1_l),
    .gdbginit_l(gdbg1_l), .cluster_cken(cken1), .se(se1), .si(si1),
    .rclk(rclk1), .cluster_grst_l(cgrst1), .dbginit_l(dbginit1_l),
    .rst_done(rst_done1), .so(so1)
  );

  // Pulse-width watcher on rclk[2], armed only while its enable is toggled
  bit  glitch_en = 1'b0;
  time last_t = 0;
  always @(rclk[2]) begin
    if (glitch_en) begin
      tests++;
      if ($time - last_t < 5) begin
        fails++;
        $display("FAIL rclk2_pulse_width: got %0t required >= 5", $time - last_t);
      end
    end
    last_t = $time;
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic test_reset();
    arst_l = 1'b0;
    repeat (3) tick();
    tests++; if (cluster_grst_l !== 4'h0) begin fails++; $display("FAIL reset_cluster_grst_l: got %h required 0", cluster_grst_l); end
    tests++; if (dbginit_l !== 1'b0) begin fails++; $display("FAIL reset_dbginit_l: got %b required 0", dbginit_l); end
    tests++; if (rst_done !== 1'b0) begin fails++; $display("FAIL reset_rst_done: got %b required 0", rst_done); end
    tests++; if (so !== 1'b0) begin fails++; $display("FAIL reset_so: got %b required 0", so); end
    tests++; if (rclk !== 4'hF) begin fails++; $display("FAIL reset_rclk_high: got %h required f", rclk); end
    @(negedge gclk); #1;
    tests++; if (rclk !== 4'h0) begin fails++; $display("FAIL reset_rclk_low: got %h required 0", rclk); end
  endtask

  task automatic test_release();
    int rise[4];
    int done_at;
    tick();
    arst_l = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) rise[i] = -1;
    done_at = -1;
    grst_l = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      for (int i = 0; i < 4; i++) if (rise[i] < 0 && cluster_grst_l[i] === 1'b1) rise[i] = k;
      if (done_at < 0 && rst_done === 1'b1) done_at = k;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rise[i] != 19 + 4 * i) begin fails++; $display("FAIL release_edge_cl%0d: got %0d required %0d", i, rise[i], 19 + 4 * i); end
    end
    tests++; if (done_at != 35) begin fails++; $display("FAIL release_rst_done_edge: got %0d required 35", done_at); end
    tests++; if (dbginit_l !== 1'b1) begin fails++; $display("FAIL release_dbginit_l: got %b required 1", dbginit_l); end
  endtask

  task automatic test_cken();
    logic exp2;
    glitch_en = 1'b1;
    @(posedge gclk); #3;
    cluster_cken[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge gclk); #1;
      exp2 = (k <= 2) ? 1'b1 : 1'b0;
      tests++; if (rclk[2] !== exp2) begin fails++; $display("FAIL cken_off_rclk2_k%0d: got %b required %b", k, rclk[2], exp2); end
      tests++; if ((rclk & 4'b1011) !== 4'b1011) begin fails++; $display("FAIL cken_off_others_k%0d: got %h required b", k, rclk & 4'b1011); end
      #3;
      tests++; if (rclk[2] !== exp2) begin fails++; $display("FAIL cken_off_rclk2_mid_k%0d: got %b required %b", k, rclk[2], exp2); end
    end
    #0 cluster_cken[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge gclk); #1;
      exp2 = (k <= 2) ? 1'b0 : 1'b1;
      tests++; if (rclk[2] !== exp2) begin fails++; $display("FAIL cken_on_rclk2_k%0d: got %b required %b", k, rclk[2], exp2); end
      tests++; if ((rclk & 4'b1011) !== 4'b1011) begin fails++; $display("FAIL cken_on_others_k%0d: got %h required b", k, rclk & 4'b1011); end
    end
    @(negedge gclk); #1;
    tests++; if (rclk !== 4'h0) begin fails++; $display("FAIL cken_rclk_low_phase: got %h required 0", rclk); end
    glitch_en = 1'b0;
    tick();
  endtask

  task automatic test_dbginit();
    int fall_at, rise_at;
    @(posedge gclk); #3;
    adbginit_l = 1'b0;
    #1;
    tests++; if (dbginit_l !== 1'b0) begin fails++; $display("FAIL adbg_async_assert: got %b required 0", dbginit_l); end
    tick();
    adbginit_l = 1'b1;
    rise_at = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (rise_at < 0 && dbginit_l === 1'b1) rise_at = k;
    end
    tests++; if (rise_at != 3) begin fails++; $display("FAIL adbg_release_edge: got %0d required 3", rise_at); end
    tests++; if (cluster_grst_l !== 4'hF) begin fails++; $display("FAIL adbg_cluster_grst_l: got %h required f", cluster_grst_l); end
    gdbginit_l = 1'b0;
    fall_at = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (fall_at < 0 && dbginit_l === 1'b0) fall_at = k;
    end
    gdbginit_l = 1'b1;
    rise_at = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (rise_at < 0 && dbginit_l === 1'b1) rise_at = k;
    end
    tests++; if (fall_at != 3) begin fails++; $display("FAIL gdbg_assert_edge: got %0d required 3", fall_at); end
    tests++; if (rise_at != 3) begin fails++; $display("FAIL gdbg_release_edge: got %0d required 3", rise_at); end
    tests++; if (cluster_grst_l !== 4'hF || rst_done !== 1'b1) begin fails++; $display("FAIL gdbg_fsm_untouched: got %h/%b required f/1", cluster_grst_l, rst_done); end
  endtask

  task automatic test_abort();
    int rise0, done_at;
    grst_l = 1'b0;
    repeat (5) tick();
    tests++; if (cluster_grst_l !== 4'h0 || rst_done !== 1'b0) begin fails++; $display("FAIL abort_pre_reset: got %h/%b required 0/0", cluster_grst_l, rst_done); end
    grst_l = 1'b1;
    repeat (23) tick();
    tests++; if (cluster_grst_l !== 4'b0011) begin fails++; $display("FAIL abort_at_cl1: got %h required 3", cluster_grst_l); end
    grst_l = 1'b0;
    repeat (2) tick();
    tests++; if (cluster_grst_l !== 4'b0011) begin fails++; $display("FAIL abort_sync_latency: got %h required 3", cluster_grst_l); end
    tick();
    tests++; if (cluster_grst_l !== 4'h0 || rst_done !== 1'b0) begin fails++; $display("FAIL abort_cleared: got %h/%b required 0/0", cluster_grst_l, rst_done); end
    repeat (3) tick();
    grst_l = 1'b1;
    rise0 = -1;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rise0 < 0 && cluster_grst_l[0] === 1'b1) rise0 = k;
      if (done_at < 0 && rst_done === 1'b1) done_at = k;
    end
    tests++; if (rise0 != 19) begin fails++; $display("FAIL abort_restart_cl0: got %0d required 19", rise0); end
    tests++; if (done_at != 35) begin fails++; $display("FAIL abort_restart_done: got %0d required 35", done_at); end
  endtask

  task automatic test_stagger0();
    int rise_at, done_at;
    tick();
    tests++; if (rclk1 !== 1'b1) begin fails++; $display("FAIL s0_reset_rclk: got %b required 1", rclk1); end
    arst1_l = 1'b1;
    repeat (2) tick();
    grst1_l = 1'b1;
    rise_at = -1;
    done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rise_at < 0 && cgrst1 === 1'b1) rise_at = k;
      if (done_at < 0 && rst_done1 === 1'b1) done_at = k;
    end
    tests++; if (rise_at != 6) begin fails++; $display("FAIL s0_release_edge: got %0d required 6", rise_at); end
    tests++; if (done_at != 7) begin fails++; $display("FAIL s0_run_edge: got %0d required 7", done_at); end
    tests++; if (rclk1 !== 1'b0) begin fails++; $display("FAIL s0_gated_rclk: got %b required 0", rclk1); end
  endtask

  task automatic test_scan();
    logic [7:0] pat;
    logic       bits [0:83];
    pat = 8'hA5;
    for (int m = 0; m < 84; m++) bits[m] = pat[7 - (m % 8)];
    cluster_cken = 4'h0;
    repeat (4) tick();
    tests++; if (rclk !== 4'h0) begin fails++; $display("FAIL scan_pre_gated: got %h required 0", rclk); end
    se = 1'b1;
    repeat (2) tick();
    tests++; if (rclk !== 4'hF) begin fails++; $display("FAIL scan_rclk_forced: got %h required f", rclk); end
    for (int m = 0; m < 84; m++) begin
      si = bits[m];
      tick();
      if (m >= 27) begin
        tests++;
        if (so !== bits[m - 27]) begin fails++; $display("FAIL scan_so_m%0d: got %b required %b", m, so, bits[m - 27]); end
      end
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  initial begin
    arst_l = 1'b1; grst_l = 1'b0; adbginit_l = 1'b1; gdbginit_l = 1'b1;
    cluster_cken = 4'hF; se = 1'b0; si = 1'b0;
    arst1_l = 1'b1; grst1_l = 1'b0; adbg1_l = 1'b1; gdbg1_l = 1'b1;
    cken1 = 1'b0; se1 = 1'b0; si1 = 1'b0;
    #2;
    arst1_l = 1'b0;
    test_reset();
    test_release();
    test_cken();
    test_dbginit();
    test_abort();
    test_stagger0();
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
